// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand magnitudes,
// with divide-by-zero and signed-overflow cases answered without iterating.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2:0]            i_mdu_op,
   input  logic [DATA_WIDTH-1:0] i_operand_a,
   input  logic [DATA_WIDTH-1:0] i_operand_b,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_result_ready,
   output logic [DATA_WIDTH-1:0] o_result,
   output logic                  o_busy
);
   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(DATA_WIDTH - 1);
   localparam logic [W-1:0]     MIN_NEG = {1'b1, {(W-1){1'b0}}};

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op;
   logic             neg;
   // opnd: multiplicand or divisor; hi/lo: product halves or remainder/quotient
   logic [W-1:0]     opnd, hi, lo;

   logic             a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf;
   logic [W-1:0]     mag_a, mag_b;
   logic [W:0]       mul_sum;
   logic             div_ge;
   logic [W-1:0]     div_diff;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     quo, rem, res;

   always_comb begin
      is_div   = i_mdu_op[2];
      a_signed = (i_mdu_op == 3'd1) || (i_mdu_op == 3'd2) || (i_mdu_op == 3'd4) || (i_mdu_op == 3'd6);
      b_signed = (i_mdu_op == 3'd1) || (i_mdu_op == 3'd4) || (i_mdu_op == 3'd6);
      a_neg    = a_signed & i_operand_a[W-1];
      b_neg    = b_signed & i_operand_b[W-1];
      // Negating the most negative value yields the correct unsigned magnitude
      mag_a    = a_neg ? -i_operand_a : i_operand_a;
      mag_b    = b_neg ? -i_operand_b : i_operand_b;
      div_zero = is_div && (i_operand_b == '0);
      div_ovf  = is_div && !i_mdu_op[0] && (i_operand_a == MIN_NEG) && (i_operand_b == '1);
   end

   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      div_ge   = {hi, lo[W-1]} >= {1'b0, opnd};
      div_diff = {hi[W-2:0], lo[W-1]} - opnd;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         op    <= '0;
         neg   <= 1'b0;
         opnd  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else if (i_flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (i_valid) begin
               op  <= i_mdu_op;
               cnt <= '0;
               if (div_zero) begin
                  hi    <= i_operand_a;
                  lo    <= '1;
                  neg   <= 1'b0;
                  state <= S_DONE;
               end else if (div_ovf) begin
                  hi    <= '0;
                  lo    <= i_operand_a;
                  neg   <= 1'b0;
                  state <= S_DONE;
               end else if (is_div) begin
                  opnd  <= mag_b;
                  hi    <= '0;
                  lo    <= mag_a;
                  neg   <= i_mdu_op[1] ? a_neg : (a_neg ^ b_neg);
                  state <= S_CALC;
               end else begin
                  opnd  <= mag_a;
                  hi    <= '0;
                  lo    <= mag_b;
                  neg   <= a_neg ^ b_neg;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               if (op[2]) begin
                  hi <= div_ge ? div_diff : {hi[W-2:0], lo[W-1]};
                  lo <= {lo[W-2:0], div_ge};
               end else begin
                  {hi, lo} <= {mul_sum, lo[W-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= S_DONE;
            end
            S_DONE: if (i_result_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      prod = neg ? -{hi, lo} : {hi, lo};
      quo  = neg ? -lo : lo;
      rem  = neg ? -hi : hi;
      case (op)
         3'd0:             res = prod[W-1:0];
         3'd1, 3'd2, 3'd3: res = prod[2*W-1:W];
         3'd4, 3'd5:       res = quo;
         default:          res = rem;
      endcase
   end

   assign o_ready  = (state == S_IDLE);
   assign o_busy   = (state != S_IDLE);
   assign o_valid  = (state == S_DONE);
   assign o_result = (state == S_DONE) ? res : '0;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed checks of mul_div_unit at widths 32 and 8 against an
// arithmetic reference model.
module tb_mul_div_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        flush = 1'b0;
   logic        rdy = 1'b0;
   logic        ready32, valid32, busy32, ready8, valid8, busy8;
   logic [31:0] res32;
   logic [7:0]  res8;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.DATA_WIDTH(32)) dut32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready32), .i_mdu_op(op),
      .i_operand_a(a), .i_operand_b(b), .i_flush(flush), .o_valid(valid32),
      .i_result_ready(rdy), .o_result(res32), .o_busy(busy32));

   mul_div_unit #(.DATA_WIDTH(8)) dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready8), .i_mdu_op(op),
      .i_operand_a(a[7:0]), .i_operand_b(b[7:0]), .i_flush(flush), .o_valid(valid8),
      .i_result_ready(rdy), .o_result(res8), .o_busy(busy8));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input int w, input logic [2:0] o,
                                          input logic [31:0] ain, input logic [31:0] bin);
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint unsigned ua = {32'd0, ain} & mask;
      longint unsigned ub = {32'd0, bin} & mask;
      longint sa = ua[w-1] ? signed'(ua) - signed'(64'd1 << w) : signed'(ua);
      longint sb = ub[w-1] ? signed'(ub) - signed'(64'd1 << w) : signed'(ub);
      longint mn = -(longint'(1) << (w - 1));
      longint sr;
      longint unsigned r;
      case (o)
         3'd0: begin sr = sa * sb; r = unsigned'(sr); end
         3'd1: begin sr = (sa * sb) >>> w; r = unsigned'(sr); end
         3'd2: begin sr = (sa * signed'(ub)) >>> w; r = unsigned'(sr); end
         3'd3: r = (ua * ub) >> w;
         3'd4: if (ub == 0) r = mask;
               else if (sa == mn && sb == -1) r = ua;
               else begin sr = sa / sb; r = unsigned'(sr); end
         3'd5: r = (ub == 0) ? mask : ua / ub;
         3'd6: if (ub == 0) r = ua;
               else if (sa == mn && sb == -1) r = 0;
               else begin sr = sa % sb; r = unsigned'(sr); end
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      r = r & mask;
      return r[31:0];
   endfunction

   function automatic bit is_fast(input int w, input logic [2:0] o,
                                  input logic [31:0] ain, input logic [31:0] bin);
      logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      logic [31:0] mn = 32'd1 << (w - 1);
      if (!o[2]) return 1'b0;
      if ((bin & mask) == 0) return 1'b1;
      return !o[0] && ((ain & mask) == mn) && ((bin & mask) == mask);
   endfunction

   // Issue one request to both widths, check latency, value, hold and handoff
   task automatic run_op(input logic [2:0] o, input logic [31:0] ain, input logic [31:0] bin, input int hold);
      logic [31:0] e32 = ref_op(32, o, ain, bin);
      logic [31:0] e8  = ref_op(8, o, ain, bin);
      int lat32 = is_fast(32, o, ain, bin) ? 0 : 32;
      int lat8  = is_fast(8, o, ain, bin) ? 0 : 8;
      bit got32 = 0, got8 = 0;
      int n = 0;
      chk("ready_before", {62'd0, ready32, ready8}, 64'd3);
      valid = 1'b1; op = o; a = ain; b = bin;
      @(posedge clk); #1;
      valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
      while (!(got32 && got8) && n <= 60) begin
         if (valid32 && !got32) begin
            chk($sformatf("lat32 op%0d", o), 64'(n), 64'(lat32));
            chk($sformatf("res32 op%0d %h %h", o, ain, bin), {32'd0, res32}, {32'd0, e32});
            got32 = 1;
         end else if (!got32) chk("res32_zero", {32'd0, res32}, 64'd0);
         if (valid8 && !got8) begin
            chk($sformatf("lat8 op%0d", o), 64'(n), 64'(lat8));
            chk($sformatf("res8 op%0d %h %h", o, ain[7:0], bin[7:0]), {56'd0, res8}, {56'd0, e8});
            got8 = 1;
         end
         if (!(got32 && got8)) begin
            @(posedge clk); #1; n++;
         end
      end
      if (!got32) chk("timeout32", 64'd0, 64'd1);
      if (!got8)  chk("timeout8", 64'd0, 64'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", {62'd0, valid32, valid8}, 64'd3);
         chk("hold_res32", {32'd0, res32}, {32'd0, e32});
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
      chk("idle_after", {60'd0, ready32, valid32, busy32, valid8}, 64'b1000);
      chk("res_zero_after", {32'd0, res32}, 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [2:0]  ro;
      bit          seen;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_state", {59'd0, ready32, valid32, busy32, ready8, valid8}, 64'b10010);
      chk("reset_res", {32'd0, res32}, 64'd0);

      run_op(3'd0, 32'd7, 32'd6, 5);
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(3'd5, 32'd100, 32'd7, 0);
      run_op(3'd7, 32'd100, 32'd7, 2);
      run_op(3'd5, 32'd5, 32'd0, 0);
      run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 1);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'd4, 32'h8000_0080, 32'hFFFF_FF03, 0);

      // Flush during a divide
      valid = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
      @(posedge clk); #1 valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      chk("flush_idle", {61'd0, ready32, busy32, valid32}, 64'b100);
      seen = 0;
      repeat (40) begin @(posedge clk); #1 if (valid32 || valid8) seen = 1; end
      chk("flush_no_result", {63'd0, seen}, 64'd0);

      // Flush together with a request in IDLE
      valid = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
      @(posedge clk); #1 valid = 1'b0; flush = 1'b0;
      chk("flush_blocks_accept", {61'd0, ready32, busy32, ready8}, 64'b101);

      // Reset in the middle of a multiply
      valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
      @(posedge clk); #1 valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("rst_mid_state", {61'd0, ready32, valid32, busy32}, 64'b100);
      chk("rst_mid_res", {32'd0, res32}, 64'd0);
      seen = 0;
      repeat (40) begin @(posedge clk); #1 if (valid32 || valid8) seen = 1; end
      chk("rst_no_result", {63'd0, seen}, 64'd0);

      for (int k = 0; k < 80; k++) begin
         ro = 3'($urandom);
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = {24'($urandom), 8'h80}; rb = {24'($urandom), 8'hFF}; end
            3: rb = $urandom_range(1, 20);
            4: ra = 32'h8000_0000;
            default: ;
         endcase
         run_op(ro, ra, rb, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
